// File: rtl/demux4_pkg.sv
// demux4_pkg: constants and types shared by the demux4_stream slice.
//   NUM_CH       number of output channels
//   SEL_W        width of the channel select
//   CNT_W        width of each per-channel transfer counter (stats build)
//   ch_sel_t     channel index type
//   slot_state_t occupancy state of a single-entry output slot
//   sel_onehot() decodes a channel index into a one-hot channel mask
package demux4_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;

  typedef logic [SEL_W-1:0] ch_sel_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_t sel);
    logic [NUM_CH-1:0] mask;
    mask = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (sel == ch_sel_t'(k)) mask[k] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/demux4_slot.sv
// demux4_slot: single-entry output buffer for one demux channel.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (empties the slot, clears data)
//   load_i    write data_i into the slot this cycle
//   data_i    word to store
//   drain_i   downstream ready; removes the word only when the slot is full
//   full_o    slot holds a word (drives the channel's valid)
//   data_q_o  stored word; keeps its value after a drain
module demux4_slot
  import demux4_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             drain_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_q_o
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             drain;

  // Ready on an empty slot is ignored.
  assign drain = (state_q == SLOT_FULL) & drain_i;

  // Load is applied after drain so that a same-edge load and drain
  // leaves the slot full with the new word.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (drain) state_d = SLOT_EMPTY;
    if (load_i) begin
      state_d = SLOT_FULL;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign full_o   = (state_q == SLOT_FULL);
  assign data_q_o = data_q;

endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 stream demultiplexer.
// One producer word per cycle (valid/ready) is steered by in_sel into one of
// four single-entry slots; each slot has its own valid/ready to its consumer.
// Optional feature: define DEMUX4_STATS_EN to add xfer_cnt, four 8-bit
// wrapping accept counters (channel k at [k*8 +: 8]).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      word to route
//   in_sel       destination channel 0..3
//   in_valid     producer offers in_data/in_sel
//   in_ready     accepted this cycle if in_valid (independent of in_valid)
//   out_data     channel k word at [k*WIDTH +: WIDTH]
//   out_valid    bit k: slot k holds a word
//   out_ready    bit k: consumer k takes slot k this cycle
//   busy         OR of out_valid
//   xfer_cnt     per-channel accept counters (DEMUX4_STATS_EN only)
module demux4_stream
  import demux4_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic                    busy
`ifdef DEMUX4_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] xfer_cnt
`endif
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] load;
  logic              accept;
  ch_sel_t           sel;

  assign sel = ch_sel_t'(in_sel);

  // The selected slot can take a word if it is empty or being drained now.
  assign in_ready = ~full[sel] | out_ready[sel];
  assign accept   = in_valid & in_ready;
  assign load     = accept ? sel_onehot(sel) : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux4_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load[k]),
      .data_i   (in_data),
      .drain_i  (out_ready[k]),
      .full_o   (full[k]),
      .data_q_o (out_data[k*WIDTH +: WIDTH])
    );
  end

  assign out_valid = full;
  assign busy      = |full;

`ifdef DEMUX4_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  // Counters wrap naturally at 2**CNT_W.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (load[k]) cnt_d[k] = cnt_q[k] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
    assign xfer_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed self-checking bench for demux4_stream.
// Per-channel expected-word queues are filled on modelled accepts and popped
// on modelled drains; all outputs are checked against the model each cycle.
module tb_demux4_stream;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic           busy;
`ifdef DEMUX4_STATS_EN
  logic [31:0]    xfer_cnt;
  logic [7:0]     exp_cnt [4];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q [4][$];

  demux4_stream #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef DEMUX4_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model at the falling edge, update the
  // model with this cycle's drains and accept, then step past the rising edge.
  task automatic cycle();
    logic [3:0] full_m;
    logic       exp_rdy;
    @(negedge clk);
    for (int k = 0; k < 4; k++) full_m[k] = (exp_q[k].size() != 0);
    check("out_valid", out_valid, full_m);
    check("busy", busy, |full_m);
    exp_rdy = ~full_m[in_sel] | out_ready[in_sel];
    check("in_ready", in_ready, exp_rdy);
`ifdef DEMUX4_STATS_EN
    check("xfer_cnt", xfer_cnt, {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]});
`endif
    for (int k = 0; k < 4; k++) begin
      if (full_m[k]) begin
        check($sformatf("data_ch%0d", k), out_data[k*W +: W], exp_q[k][0]);
        if (out_ready[k]) void'(exp_q[k].pop_front());
      end
    end
    if (in_valid && exp_rdy) begin
      exp_q[in_sel].push_back(in_data);
`ifdef DEMUX4_STATS_EN
      exp_cnt[in_sel] = exp_cnt[in_sel] + 8'd1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset away from any clock edge, checks the immediate effect,
  // then releases it at a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 4'b0000);
    check("rst_out_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
`ifdef DEMUX4_STATS_EN
    check("rst_xfer_cnt", xfer_cnt, 32'd0);
    for (int k = 0; k < 4; k++) exp_cnt[k] = 8'd0;
`endif
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_data   = '0;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;

    // Reset, then idle: ready for every channel.
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check($sformatf("idle_ready_sel%0d", s), in_ready, 1'b1);
    end
    cycle();

    // Single word to channel 2, held until its consumer takes it.
    in_data  = 4'hA;
    in_sel   = 2'd2;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("single_valid", out_valid, 4'b0100);
    check("single_data", out_data[11:8], 4'hA);
    cycle();
    cycle();
    out_ready = 4'b0100;
    cycle();
    out_ready = 4'b0000;
    check("single_drained", out_valid, 4'b0000);
    cycle();

    // Back-pressure on channel 1; channel 3 still accepted meanwhile.
    in_data  = 4'h5;
    in_sel   = 2'd1;
    in_valid = 1'b1;
    cycle();
    in_data = 4'h7;
    in_sel  = 2'd3;
    cycle();
    in_data = 4'h6;
    in_sel  = 2'd1;
    #1;
    check("bp_stall_ready", in_ready, 1'b0);
    cycle();
    cycle();
    out_ready = 4'b0010;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("bp_held_word", out_data[7:4], 4'h6);
    cycle();
    out_ready = 4'b1000;
    cycle();
    out_ready = 4'b0000;
    cycle();

    // Streaming 0..15 into channel 0 with the consumer always ready.
    out_ready = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      in_data  = 4'(i);
      in_sel   = 2'd0;
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // Round-robin over all channels, all consumers ready.
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_data  = 4'(8 + i);
      in_sel   = 2'(i);
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // Fill every slot, then reset mid-operation.
    out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_data  = 4'(12 + i);
      in_sel   = 2'(i);
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    check("all_full", out_valid, 4'b1111);
    cycle();
    apply_reset();
    cycle();

    // 256 accepts to channel 0 (counter wraps back to 0 in the stats build).
    out_ready = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      in_data  = 4'(i);
      in_sel   = 2'd0;
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
`ifdef DEMUX4_STATS_EN
    check("cnt_wrap", xfer_cnt[7:0], 8'd0);
`endif
    cycle();
    cycle();
    out_ready = 4'b0000;

    for (int k = 0; k < 4; k++) begin
      check($sformatf("sb_empty_ch%0d", k), exp_q[k].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
